// File: rtl/div_ctrl_if.sv
// div_ctrl_if: request and response channels between the M-extension issue logic and div_ctrl.
// The master drives requests and consumes responses; the slave is the sequencer.
interface div_ctrl_if #(
   parameter int N     = 32,
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [N-1:0]     req_dividend;
   logic [N-1:0]     req_divisor;
   logic [1:0]       req_op;
   logic [TAG_W-1:0] req_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [N-1:0]     rsp_data;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output req_valid, req_dividend, req_divisor, req_op, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor, req_op, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: one-at-a-time sequencer for the radix-2 SRT divider (DIV/DIVU/REM/REMU).
// Define DIV_FASTPATH_EN to resolve divisors 0, 1 and -1 at accept without the divider.
module div_ctrl #(
   parameter int N     = 32,
   parameter int TAG_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   div_ctrl_if.slave    bus,
   input  logic         flush,
   output logic         busy,
   output logic         div_rst,
   output logic [N-1:0] div_dividend,
   output logic [N-1:0] div_divisor,
   output logic [1:0]   div_op,
   input  logic [N-1:0] div_out,
   input  logic         div_done
);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     dividend_q, dividend_d;
   logic [N-1:0]     divisor_q, divisor_d;
   logic [1:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [N-1:0]     rsp_data_q, rsp_data_d;

   logic             req_ready;
   logic             accept;
   logic             fast_hit;
   logic [N-1:0]     fast_data;

   assign req_ready = (state_q == IDLE) && !flush && !rst;
   assign accept    = bus.req_valid && req_ready;

`ifdef DIV_FASTPATH_EN
   localparam logic [1:0] OP_DIV = 2'b00;
   localparam logic [1:0] OP_REM = 2'b10;

   // op[1] selects remainder; results match what the divider would return.
   always_comb begin
      fast_hit  = 1'b1;
      fast_data = '0;
      if (bus.req_divisor == '0)
         fast_data = bus.req_op[1] ? bus.req_dividend : '1;
      else if (bus.req_divisor == {{(N-1){1'b0}}, 1'b1})
         fast_data = bus.req_op[1] ? '0 : bus.req_dividend;
      else if (bus.req_divisor == '1 && bus.req_op == OP_DIV)
         fast_data = -bus.req_dividend;
      else if (bus.req_divisor == '1 && bus.req_op == OP_REM)
         fast_data = '0;
      else
         fast_hit = 1'b0;
   end
`else
   assign fast_hit  = 1'b0;
   assign fast_data = '0;
`endif

   always_comb begin
      // NOTE: every _d starts at its held value so no branch can infer a latch.
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      op_d       = op_q;
      tag_d      = tag_q;
      rsp_data_d = rsp_data_q;

      // Flush outranks everything; a result arriving with it is dropped.
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               dividend_d = bus.req_dividend;
               divisor_d  = bus.req_divisor;
               op_d       = bus.req_op;
               tag_d      = bus.req_tag;
               state_d    = fast_hit ? RESP : RUN;
               if (fast_hit) rsp_data_d = fast_data;
            end
            RUN: if (div_done) begin
               rsp_data_d = div_out;
               state_d    = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: operand and result registers are reset too, so div_* and rsp_* read zero out of reset.
      if (rst) begin
         state_q    <= IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         op_q       <= '0;
         tag_q      <= '0;
         rsp_data_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         op_q       <= op_d;
         tag_q      <= tag_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Holding the divider in reset outside RUN keeps div_done low on entry and blocks auto-restart.
   assign div_rst       = rst || (state_q != RUN);
   assign div_dividend  = dividend_q;
   assign div_divisor   = divisor_q;
   assign div_op        = op_q;
   assign busy          = (state_q != IDLE);
   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_tag   = tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a cycle-timed behavioural divider.
// Builds with or without DIV_FASTPATH_EN; expected latencies follow the build.
module tb_div_ctrl;
  localparam int N     = 32;
  localparam int TAG_W = 5;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy;
  logic        div_rst;
  logic [31:0] div_dividend, div_divisor, div_out;
  logic [1:0]  div_op;
  logic        div_done;

  div_ctrl_if #(.N(N), .TAG_W(TAG_W)) bus ();

  div_ctrl #(.N(N), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush        (flush),
    .busy         (busy),
    .div_rst      (div_rst),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_op       (div_op),
    .div_out      (div_out),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural divider: RISC-V M results, done 36 cycles after release (3 for a zero divisor).
  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      OP_DIV:  return ovf ? a : 32'($signed(a) / $signed(b));
      OP_DIVU: return a / b;
      OP_REM:  return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  int unsigned dcnt;
  always @(posedge clk) begin
    if (div_rst) dcnt <= 0;
    else         dcnt <= dcnt + 1;
  end
  assign div_done = !div_rst && (dcnt == ((div_divisor == 32'd0) ? 32'd2 : 32'd35));
  assign div_out  = div_ref(div_dividend, div_divisor, div_op);

  function automatic int exp_lat(input logic [31:0] b, input logic [1:0] op);
`ifdef DIV_FASTPATH_EN
    if (b == 32'd0 || b == 32'd1 || (b == 32'hFFFF_FFFF && !op[0])) return 1;
`endif
    return (b == 32'd0) ? 4 : 37;
  endfunction

  // Scoreboard
  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input string nm, input logic [31:0] b, input logic [1:0] op,
                          input logic [4:0] tag, input logic [31:0] data);
    exp_t e;
    e.name = nm; e.data = data; e.tag = tag; e.lat = exp_lat(b, op);
    sb.push_back(e);
  endtask

  int   acc_cyc, first_cyc, run_cnt;
  logic prev_valid = 1'b0, prev_hs = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
      if (bus.rsp_valid && !prev_valid) first_cyc = cyc;
      if (!div_rst) run_cnt++;
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc;
        run_cnt = 0;
      end
      prev_hs = bus.rsp_valid && bus.rsp_ready;
      if (prev_hs) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, bus.rsp_data, e.data);
          check({e.name, "_tag"}, 32'(bus.rsp_tag), 32'(e.tag));
          check({e.name, "_latency"}, 32'(first_cyc - acc_cyc), 32'(e.lat));
          check({e.name, "_run_cycles"}, 32'(run_cnt), 32'(e.lat - 1));
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // Stimulus helpers; each is entered and left 1 time unit after a rising edge.
  task automatic send(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [4:0] tag, input logic [31:0] exp, output int t_acc);
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_op       = op;
    bus.req_tag      = tag;
    bus.req_valid    = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        t_acc = cyc;
        break;
      end
    end
    if (t_acc < 0) check({nm, "_accept"}, 32'(bus.req_ready), 32'd1);
    else push_exp(nm, b, op, tag, exp);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check({nm, "_drain"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    check({nm, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic quiet(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check({nm, "_no_rsp"}, 32'(seen), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string p);
    check({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({p, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({p, "_rsp_tag"}, 32'(bus.rsp_tag), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_div_rst"}, 32'(div_rst), 32'd1);
    check({p, "_div_dividend"}, div_dividend, 32'd0);
    check({p, "_div_divisor"}, div_divisor, 32'd0);
    check({p, "_div_op"}, 32'(div_op), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin : main
    int t;
    vecs[0]  = '{32'd100,        32'd7,          OP_DIV,  5'd3,  32'd14};
    vecs[1]  = '{32'hFFFF_FF9C,  32'd7,          OP_REM,  5'd4,  32'hFFFF_FFFE};
    vecs[2]  = '{32'hFFFF_FFFF,  32'd16,         OP_REMU, 5'd5,  32'd15};
    vecs[3]  = '{32'hFFFF_FFFF,  32'd16,         OP_DIVU, 5'd6,  32'h0FFF_FFFF};
    vecs[4]  = '{32'd5,          32'd0,          OP_DIVU, 5'd7,  32'hFFFF_FFFF};
    vecs[5]  = '{32'd5,          32'd0,          OP_REM,  5'd8,  32'd5};
    vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_DIV,  5'd9,  32'h8000_0000};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_REM,  5'd10, 32'd0};
    vecs[8]  = '{32'd12345,      32'd1,          OP_DIV,  5'd11, 32'd12345};
    vecs[9]  = '{32'd7,          32'd1,          OP_REMU, 5'd12, 32'd0};
    vecs[10] = '{32'd10,         32'hFFFF_FFFF,  OP_DIV,  5'd13, 32'hFFFF_FFF6};
    vecs[11] = '{32'd10,         32'hFFFF_FFFF,  OP_DIVU, 5'd14, 32'd0};
    vecs[12] = '{32'hFFFF_FFF9,  32'd2,          OP_DIV,  5'd31, 32'hFFFF_FFFD};

    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_dividend = 32'd1;
    bus.req_divisor = 32'd1;
    bus.req_op = OP_DIV;
    bus.req_tag = 5'd1;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    reset_checks("reset");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, vecs[i].exp, t);
      wait_idle($sformatf("vec%0d", i));
    end

    // Backpressure, then a request offered in the same cycle the response is taken.
    bus.rsp_ready = 1'b0;
    send("bp", 32'd1000, 32'd10, OP_DIVU, 5'd7, 32'd100, t);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_data", bus.rsp_data, 32'd100);
      check("bp_hold_tag", 32'(bus.rsp_tag), 32'd7);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_dividend = 32'd81;
    bus.req_divisor = 32'd9;
    bus.req_op = OP_DIV;
    bus.req_tag = 5'd13;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("bp_no_turnaround", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_accept_next", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready) push_exp("bp_next", 32'd9, OP_DIV, 5'd13, 32'd9);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle("bp_next");

    // Flush mid-RUN at T+20.
    send("flush_run", 32'd1000, 32'd3, OP_DIV, 5'd9, 32'd333, t);
    goto_cycle(t + 20);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_div_rst", 32'(div_rst), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    quiet("flush_run", 50);
    send("after_flush", 32'd9, 32'd3, OP_DIV, 5'd12, 32'd3, t);
    wait_idle("after_flush");

    // Flush in the same cycle as div_done.
    send("flush_done", 32'd50, 32'd5, OP_DIV, 5'd2, 32'd10, t);
    goto_cycle(t + 36);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_seen", 32'(div_done), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    quiet("flush_done", 20);

    // Flush during RESP drops the response.
    bus.rsp_ready = 1'b0;
    send("flush_resp", 32'd40, 32'd4, OP_DIVU, 5'd21, 32'd10, t);
    wait_valid("flush_resp");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.rsp_ready = 1'b1;
    sb.delete();
    quiet("flush_resp", 20);

    // Reset mid-RUN.
    send("rst_run", 32'd77, 32'd7, OP_DIVU, 5'd5, 32'd11, t);
    goto_cycle(t + 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    reset_checks("rst_run");
    @(posedge clk); #1;
    quiet("rst_run", 50);

    // Reset during RESP.
    bus.rsp_ready = 1'b0;
    send("rst_resp", 32'd8, 32'd3, OP_REMU, 5'd6, 32'd2, t);
    wait_valid("rst_resp");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    reset_checks("rst_resp");
    @(posedge clk); #1;
    quiet("rst_resp", 20);

    send("final", 32'd200, 32'd8, OP_DIVU, 5'd17, 32'd25, t);
    wait_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer and request front-end for the radix-2 SRT divider in the RV32IM M-extension path. Accepts one DIV/DIVU/REM/REMU request at a time over a valid/ready handshake and latches operands. Launches the divider by releasing its reset, captures its result on `done`, and returns it with the request tag over a valid/ready response channel. Supports pipeline flush and an optional fast path for trivial divisors.

## Interface
- `N`, 32, operand/result width.
- `TAG_W`, 5, request tag width (destination register index).

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_dividend`  in  N  dividend.
- `req_divisor`  in  N  divisor.
- `req_op`  in  2  op code: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_tag`  in  TAG_W  tag returned with the result.
- `flush`  in  1  abort the in-flight or pending operation.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  N  quotient or remainder.
- `rsp_tag`  out  TAG_W  tag of the result.
- `busy`  out  1  state is not IDLE.
- `div_rst`  out  1  divider reset; low only while running.
- `div_dividend`, `div_divisor`  out  N  latched operands to the divider.
- `div_op`  out  2  latched op to the divider.
- `div_out`  in  N  divider result.
- `div_done`  in  1  divider completion flag.

## Operation
- States and transitions:
  - IDLE → RUN on accept.
  - IDLE → RESP on accept with the fast path hit.
  - RUN → RESP on `div_done`.
  - RESP → IDLE on `rsp_ready`.
- `req_ready = (state==IDLE) && !flush && !rst`.
- On accept, latch dividend, divisor, op and tag into operand registers. These registers drive `div_*` continuously.
- `div_rst = rst || (state != RUN)`. The divider therefore sits in reset outside RUN, and `div_done` is guaranteed low on entry to RUN.
- RUN, on the first cycle `div_done==1`:
  - Capture `div_out` into `rsp_data`.
  - Go to RESP.
  - `div_rst` rises the next cycle, which suppresses the divider's automatic restart.
- RESP:
  - `rsp_valid=1`.
  - `rsp_data` and `rsp_tag` are held stable until `rsp_ready`.
  - Return to IDLE on `rsp_ready`. A new request is acceptable only from the following cycle; there is no same-cycle turnaround.
- `flush` has priority over every other event in every state:
  - RUN: go to IDLE and discard the result.
  - RESP: drop the response; `rsp_valid` falls next cycle.
  - IDLE: no accept occurs that cycle.
- `flush` together with `div_done` in the same cycle: the result is discarded.
- `rst` mid-operation: return to IDLE immediately, with no response.
- Output reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `busy=0`.
  - `req_ready=0` during the reset cycle.
  - `div_rst=1`, `div_*` operands 0.
- Results follow RISC-V M semantics, as computed by the divider:
  - Divide by zero: quotient is all ones, remainder is the dividend.
  - Signed overflow (0x80000000 / −1): quotient is 0x80000000, remainder is 0.

## Timing
- Accept in cycle T; RUN from T+1.
- Nonzero divisor, no fast path:
  - `div_done` is seen at T+36.
  - `rsp_valid` is high from T+37.
  - Accept-to-response latency is 37 cycles.
- Divisor 0 without fast path: `div_done` at T+3, `rsp_valid` at T+4.
- Fast-path hit: `rsp_valid` at T+1; the divider is never released from reset.
- Throughput: one operation in flight at a time. Back-to-back operations are spaced by response latency, plus the `rsp_ready` stall, plus 1 cycle.
- `busy` is registered: high from T+1 until the cycle after the response is taken or flushed.

## Configuration
- Macro `DIV_FASTPATH_EN`.
- Defined: at accept, the following cases bypass the divider and go straight to RESP:
  - `divisor==0`: result is the dividend for REM/REMU, 0xFFFFFFFF for DIV/DIVU.
  - `divisor==1`: result is the dividend for DIV/DIVU, 0 for REM/REMU.
  - `divisor==0xFFFFFFFF` with DIV: result is −dividend (mod 2^N).
  - `divisor==0xFFFFFFFF` with REM: result is 0.
- Undefined: every request goes through RUN. Results are identical in both builds; only latency differs.

## Test plan
- DIV 100 / 7, tag 3, `rsp_ready=1` → `rsp_data`=14, `rsp_tag`=3, `rsp_valid` exactly at T+37, one-cycle pulse.
- REM −100 (0xFFFFFF9C) / 7 → 0xFFFFFFFE; REMU 0xFFFFFFFF / 16 → 15; DIVU 0xFFFFFFFF / 16 → 0x0FFFFFFF.
- DIVU 5 / 0 → 0xFFFFFFFF at T+4 without `DIV_FASTPATH_EN`, at T+1 with it. REM 5 / 0 → 5.
- Response backpressure: hold `rsp_ready=0` for 10 cycles → `rsp_valid`/`rsp_data` stable, `req_ready=0` throughout. Response accepted on release, new request accepted the next cycle.
- `flush` at T+20 of a DIV → no `rsp_valid`, `div_rst` high at T+21, `busy` low at T+21. Follow-up DIV 9 / 3 → 3 with correct tag.
- Assert `rst` mid-RUN and also during RESP → all outputs at reset values next cycle; no stale response afterward.
